// File: rtl/triumph_dcache_pkg.sv
// Shared definitions for the Triumph data cache: FSM state encodings,
// default line count and the byte-merge helper used by the line store.
package triumph_dcache_pkg;

   localparam int unsigned DC_LINES_DEFAULT = 16;

   typedef enum logic [1:0] {
      DC_IDLE    = 2'd0,
      DC_WR_REQ  = 2'd1,
      DC_RD_REQ  = 2'd2,
      DC_RD_WAIT = 2'd3
   } dc_state_e;

   // Replace the bytes of cur selected by be with the matching bytes of upd.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] upd,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int unsigned b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = upd[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/triumph_dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Combinational read port, one byte-enabled write port that also sets the
// line valid and tag; reset invalidates every line.
module triumph_dcache_array
   import triumph_dcache_pkg::*;
#(
   parameter int unsigned LINES = DC_LINES_DEFAULT,
   localparam int unsigned IDX_W = $clog2(LINES),
   localparam int unsigned TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data,
   input  logic [3:0]       wr_be
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   // Valid bits: cleared by reset, set by any line write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data payload: no reset needed, qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= merge_bytes(data_q[wr_idx], wr_data, wr_be);
      end
   end

   // Combinational lookup.
   always_comb begin
      rd_valid = valid_q[rd_idx];
      rd_tag   = tag_q[rd_idx];
      rd_data  = data_q[rd_idx];
   end

endmodule

// File: rtl/triumph_dcache.sv
// Triumph MEM-stage data cache: direct-mapped, write-through,
// no-write-allocate, one word per line. Optional performance counters are
// enabled with the TRIUMPH_DCACHE_PERF_EN macro (hit_cnt_o, miss_cnt_o).
module triumph_dcache
   import triumph_dcache_pkg::*;
#(
   parameter int unsigned LINES = DC_LINES_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic        req_read_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic        mem_req_write_o,
   output logic [31:0] mem_req_addr_o,
   output logic [31:0] mem_req_wdata_o,
   output logic [3:0]  mem_req_be_o,
   input  logic        mem_rsp_valid_i,
   input  logic [31:0] mem_rsp_rdata_i
`ifdef TRIUMPH_DCACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   dc_state_e state, state_next;

   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        write_q;

   logic             op_write, op_read, hit;
   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             line_valid;
   logic [TAG_W-1:0] line_tag;
   logic [31:0]      line_data;

   logic             latch_wr, latch_rd, load_hit, load_fill;
   logic             arr_we;
   logic [IDX_W-1:0] arr_idx;
   logic [TAG_W-1:0] arr_tag;
   logic [31:0]      arr_data;
   logic [3:0]       arr_be;

   // Byte offset never participates in index/tag.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr_i[1:0];

   assign op_write = req_valid_i & req_write_i;
   assign op_read  = req_valid_i & req_read_i & ~req_write_i;
   assign req_idx  = req_addr_i[2+IDX_W-1:2];
   assign req_tag  = req_addr_i[31:2+IDX_W];
   assign fill_idx = addr_q[2+IDX_W-1:2];
   assign fill_tag = addr_q[31:2+IDX_W];
   assign hit      = line_valid && (line_tag == req_tag);

   assign mem_req_write_o = write_q;
   assign mem_req_addr_o  = addr_q;
   assign mem_req_wdata_o = wdata_q;
   assign mem_req_be_o    = be_q;

   triumph_dcache_array #(
      .LINES (LINES)
   ) u_array (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .rd_idx   (req_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (arr_we),
      .wr_idx   (arr_idx),
      .wr_tag   (arr_tag),
      .wr_data  (arr_data),
      .wr_be    (arr_be)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= DC_IDLE;
      else         state <= state_next;
   end

   // Next-state, stall, memory-request valid and line-write steering.
   always_comb begin
      state_next      = state;
      stall_o         = 1'b0;
      mem_req_valid_o = 1'b0;
      latch_wr        = 1'b0;
      latch_rd        = 1'b0;
      load_hit        = 1'b0;
      load_fill       = 1'b0;
      arr_we          = 1'b0;
      arr_idx         = req_idx;
      arr_tag         = req_tag;
      arr_data        = req_wdata_i;
      arr_be          = req_be_i;
      case (state)
         DC_IDLE: begin
            if (op_write) begin
               // Write-through: update a hit line now, never allocate on miss.
               stall_o    = 1'b1;
               latch_wr   = 1'b1;
               arr_we     = hit;
               state_next = DC_WR_REQ;
            end else if (op_read) begin
               if (hit) begin
                  load_hit = 1'b1;
               end else begin
                  stall_o    = 1'b1;
                  latch_rd   = 1'b1;
                  state_next = DC_RD_REQ;
               end
            end
         end
         DC_WR_REQ: begin
            mem_req_valid_o = 1'b1;
            stall_o         = !mem_req_ready_i;
            if (mem_req_ready_i) state_next = DC_IDLE;
         end
         DC_RD_REQ: begin
            mem_req_valid_o = 1'b1;
            stall_o         = 1'b1;
            if (mem_req_ready_i) state_next = DC_RD_WAIT;
         end
         DC_RD_WAIT: begin
            stall_o = !mem_rsp_valid_i;
            if (mem_rsp_valid_i) begin
               arr_we     = 1'b1;
               arr_idx    = fill_idx;
               arr_tag    = fill_tag;
               arr_data   = mem_rsp_rdata_i;
               arr_be     = 4'hF;
               load_fill  = 1'b1;
               state_next = DC_IDLE;
            end
         end
         default: state_next = DC_IDLE;
      endcase
   end

   // Memory-request registers, latched when leaving IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
      end else if (latch_wr) begin
         addr_q  <= {req_addr_i[31:2], 2'b00};
         wdata_q <= req_wdata_i;
         be_q    <= req_be_i;
         write_q <= 1'b1;
      end else if (latch_rd) begin
         addr_q  <= {req_addr_i[31:2], 2'b00};
         be_q    <= 4'hF;
         write_q <= 1'b0;
      end
   end

   // Registered load data with a one-cycle qualifier pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_o       <= '0;
         rdata_valid_o <= 1'b0;
      end else begin
         rdata_valid_o <= load_hit | load_fill;
         if (load_hit)       rdata_o <= line_data;
         else if (load_fill) rdata_o <= mem_rsp_rdata_i;
      end
   end

`ifdef TRIUMPH_DCACHE_PERF_EN
   // Saturating read hit/miss counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (load_hit && (hit_cnt_o != '1))  hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (latch_rd && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_triumph_dcache.sv
// Scoreboard bench for triumph_dcache: expected load data is queued at
// retirement and checked by an independent monitor on rdata_valid_o.
module tb_triumph_dcache;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req_valid_i, req_write_i, req_read_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_be_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
   logic [31:0] mem_req_addr_o, mem_req_wdata_o;
   logic [3:0]  mem_req_be_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_rdata_i;
`ifdef TRIUMPH_DCACHE_PERF_EN
   logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

   triumph_dcache #(.LINES(16)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_write_i     (req_write_i),
      .req_read_i      (req_read_i),
      .req_addr_i      (req_addr_i),
      .req_wdata_i     (req_wdata_i),
      .req_be_i        (req_be_i),
      .stall_o         (stall_o),
      .rdata_o         (rdata_o),
      .rdata_valid_o   (rdata_valid_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_write_o (mem_req_write_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_be_o    (mem_req_be_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_rdata_i (mem_rsp_rdata_i)
`ifdef TRIUMPH_DCACHE_PERF_EN
      ,
      .hit_cnt_o       (hit_cnt_o),
      .miss_cnt_o      (miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- backing memory model ----------------
   int unsigned ready_delay = 0, rsp_delay = 0;
   int unsigned req_wait = 0, rsp_wait = 0;
   logic        pending = 1'b0, stale_rsp = 1'b0;
   logic [31:0] rsp_data = '0;
   logic [31:0] wmem [256];
   logic [255:0] written = '0;
   int unsigned wr_hs = 0, rd_hs = 0;
   logic [31:0] last_addr = '0, last_wdata = '0;
   logic [3:0]  last_be = '0;
   logic        last_write = 1'b0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'hDEAD_BEEF;
         32'h140: return 32'h0140_0140;
         32'h180: return 32'hA5A5_5A5A;
         32'h1C0: return 32'h1122_3344;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] cur_word(input logic [31:0] a);
      logic [7:0] w;
      w = a[9:2];
      return written[w] ? wmem[w] : init_word(a);
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] c, input logic [31:0] u, input logic [3:0] be);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = u[8*b +: 8];
      return r;
   endfunction

   assign mem_req_ready_i = mem_req_valid_o && (req_wait >= ready_delay);
   assign mem_rsp_valid_i = (pending && (rsp_wait >= rsp_delay)) || stale_rsp;
   assign mem_rsp_rdata_i = stale_rsp ? 32'h9999_9999 : rsp_data;

   always @(posedge clk) begin
      if (!rst_ni) begin
         pending  <= 1'b0;
         req_wait <= 0;
         rsp_wait <= 0;
      end else begin
         if (mem_req_valid_o && !mem_req_ready_i) req_wait <= req_wait + 1;
         else                                     req_wait <= 0;
         if (mem_req_valid_o && mem_req_ready_i) begin
            last_addr  <= mem_req_addr_o;
            last_wdata <= mem_req_wdata_o;
            last_be    <= mem_req_be_o;
            last_write <= mem_req_write_o;
            if (mem_req_write_o) begin
               wr_hs <= wr_hs + 1;
               wmem[mem_req_addr_o[9:2]]    <= tb_merge(cur_word(mem_req_addr_o), mem_req_wdata_o, mem_req_be_o);
               written[mem_req_addr_o[9:2]] <= 1'b1;
            end else begin
               rd_hs    <= rd_hs + 1;
               pending  <= 1'b1;
               rsp_wait <= 0;
               rsp_data <= cur_word(mem_req_addr_o);
            end
         end else if (pending) begin
            if (mem_rsp_valid_i) pending <= 1'b0;
            else                 rsp_wait <= rsp_wait + 1;
         end
      end
   end

   // ---------------- request stability watcher ----------------
   logic        snap_on = 1'b0;
   logic [68:0] snap = '0;
   int unsigned unstable = 0;

   always @(negedge clk) begin
      if (rst_ni && mem_req_valid_o) begin
         if (snap_on) begin
            if ({mem_req_write_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o} !== snap)
               unstable <= unstable + 1;
         end else begin
            snap <= {mem_req_write_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o};
         end
         snap_on <= !mem_req_ready_i;
      end else begin
         snap_on <= 1'b0;
      end
   end

   // ---------------- scoreboard and monitor ----------------
   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst_ni && rdata_valid_o) begin
         if (sb.size() == 0) begin
            check("spurious_rdata_valid", {31'b0, rdata_valid_o}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rdata", rdata_o, mon_e.data);
            check("rdata_latency_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Present one op (called at posedge+1), wait for retirement, count stalls.
   task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_data, output int stalls);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_read_i  = rd;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_be_i    = be;
      stalls      = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!stall_o) break;
         stalls++;
      end
      if (stall_o) check("op_timeout", {31'b0, stall_o}, 32'd0);
      else if (rd && !wr) sb.push_back('{exp_data, cyc + 1});
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_read_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int s;

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_read_i  = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_be_i    = '0;
      #12;
      check("rst_stall", {31'b0, stall_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_rdata_valid", {31'b0, rdata_valid_o}, 32'd0);
      check("rst_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
      check("rst_mem_write", {31'b0, mem_req_write_o}, 32'd0);
      check("rst_mem_addr", mem_req_addr_o, 32'd0);
      check("rst_mem_wdata", mem_req_wdata_o, 32'd0);
      check("rst_mem_be", {28'b0, mem_req_be_o}, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Cold read miss, then hit.
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, s);
      check("miss_stalls", s, 2);
      check("miss_req_addr", last_addr, 32'h100);
      check("miss_req_write", {31'b0, last_write}, 32'd0);
      check("miss_req_be", {28'b0, last_be}, 32'hF);
      check("miss_rd_count", rd_hs, 1);
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, s);
      check("hit_stalls", s, 0);
      check("hit_no_mem_req", rd_hs, 1);

      // Partial store to a cached line, then read back.
      do_op(1'b1, 1'b0, 32'h100, 32'h0000_CAFE, 4'b0011, 32'h0, s);
      check("store_stalls", s, 1);
      check("store_wr_count", wr_hs, 1);
      check("store_req_write", {31'b0, last_write}, 32'd1);
      check("store_req_addr", last_addr, 32'h100);
      check("store_req_be", {28'b0, last_be}, 32'h3);
      check("store_req_wdata", last_wdata, 32'h0000_CAFE);
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_CAFE, s);
      check("store_hit_read_stalls", s, 0);

      // Store to an uncached line does not allocate.
      do_op(1'b1, 1'b0, 32'h200, 32'h1234_5678, 4'hF, 32'h0, s);
      check("nwa_store_stalls", s, 1);
      check("nwa_wr_count", wr_hs, 2);
      do_op(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 32'h1234_5678, s);
      check("nwa_read_misses", s, 2);
      check("nwa_rd_count", rd_hs, 2);

      // Conflict misses on index 0.
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_CAFE, s);
      check("conflict_a_stalls", s, 2);
      do_op(1'b0, 1'b1, 32'h140, 32'h0, 4'h0, 32'h0140_0140, s);
      check("conflict_b_stalls", s, 2);
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_CAFE, s);
      check("conflict_a_again_stalls", s, 2);
      check("conflict_rd_count", rd_hs, 5);

      // Back-to-back hits.
      for (int i = 0; i < 3; i++) begin
         do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_CAFE, s);
         check("b2b_hit_stalls", s, 0);
      end
      check("b2b_rd_count", rd_hs, 5);

      // Write has priority when both selects are raised.
      do_op(1'b1, 1'b1, 32'h300, 32'h0BAD_F00D, 4'hF, 32'h0, s);
      check("wprio_stalls", s, 1);
      check("wprio_wr_count", wr_hs, 3);
      check("wprio_req_write", {31'b0, last_write}, 32'd1);
      do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 32'hDEAD_CAFE, s);
      check("wprio_no_alloc_hit", s, 0);

      // Backpressure: 5 not-ready cycles, response 3 cycles late.
      ready_delay = 5;
      rsp_delay   = 3;
      do_op(1'b0, 1'b1, 32'h180, 32'h0, 4'h0, 32'hA5A5_5A5A, s);
      check("bp_stalls", s, 10);
      check("bp_req_addr", last_addr, 32'h180);
      check("bp_unstable", unstable, 0);
      ready_delay = 0;

      // Reset while waiting for a read response.
      rsp_delay   = 50;
      req_valid_i = 1'b1;
      req_read_i  = 1'b1;
      req_addr_i  = 32'h1C0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (mem_req_valid_o && mem_req_ready_i) break;
      end
      @(posedge clk);
      #1;
      check("rdwait_stall", {31'b0, stall_o}, 32'd1);
      check("rdwait_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
      #1;
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_read_i  = 1'b0;
      #1;
      check("async_rst_stall", {31'b0, stall_o}, 32'd0);
      check("async_rst_mem_addr", mem_req_addr_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      stale_rsp = 1'b1;
      @(negedge clk);
      check("stale_stall", {31'b0, stall_o}, 32'd0);
      check("stale_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      stale_rsp = 1'b0;
      @(negedge clk);
      check("stale_no_rdata_valid", {31'b0, rdata_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      rsp_delay = 0;
      do_op(1'b0, 1'b1, 32'h1C0, 32'h0, 4'h0, 32'h1122_3344, s);
      check("post_rst_miss_stalls", s, 2);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
`ifdef TRIUMPH_DCACHE_PERF_EN
      check("perf_hit_cnt", hit_cnt_o, 32'd0);
      check("perf_miss_cnt", miss_cnt_o, 32'd1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
